// File: rtl/perm_pkg.sv
// Shared widths and types for the 16-lane permutation address blocks.
package perm_pkg;
  localparam int PERM_LANES = 16;
  localparam int PERM_AW    = 4;
  localparam int PERM_TW    = 4;
  localparam int PERM_W     = PERM_LANES*PERM_AW + PERM_TW;

  typedef logic [PERM_AW-1:0] lane_addr_t;
  typedef logic [PERM_W-1:0]  perm_word_t;

  // hit[j][i] = source lane i targets destination j
  typedef logic [PERM_LANES-1:0][PERM_LANES-1:0] hit_mat_t;

  typedef struct packed {
    logic [PERM_TW-1:0] tag;
    hit_mat_t           hit;
  } s1_ent_t;
endpackage

// File: rtl/perm_inv_core.sv
// Combinational inverse: one-hot hit matrix -> per-destination source lane.
// Error output exists only when PERM_ADDR_INV_CHECK_EN is defined.
module perm_inv_core
  import perm_pkg::*;
(
  input  hit_mat_t                             hit,
  output logic [PERM_LANES-1:0][PERM_AW-1:0]   dst
`ifdef PERM_ADDR_INV_CHECK_EN
  ,
  output logic                                 err
`endif
);

  genvar j;
  generate
    for (j = 0; j < PERM_LANES; j++) begin : g_dst
      lane_addr_t sel;
      // Scan high to low so the lowest hitting lane wins; no hit keeps identity.
      always_comb begin
        sel = lane_addr_t'(j);
        for (int i = PERM_LANES-1; i >= 0; i--)
          if (hit[j][i]) sel = lane_addr_t'(i);
      end
      assign dst[j] = sel;
    end
  endgenerate

`ifdef PERM_ADDR_INV_CHECK_EN
  // A bijection hits every destination exactly once.
  always_comb begin
    err = 1'b0;
    for (int k = 0; k < PERM_LANES; k++)
      if (!$onehot(hit[k])) err = 1'b1;
  end
`endif

endmodule

// File: rtl/perm_addr_inv.sv
// 2-stage valid/ready inverse address encoder (src[] -> dst[]).
// PERM_ADDR_INV_CHECK_EN enables the bijection check, m_err and err_cnt.
module perm_addr_inv
  import perm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [PERM_W-1:0] s_dat,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [PERM_W-1:0] m_dat,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_err,
  output logic [15:0]       err_cnt
);

  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe_q, vld_pipe_d;
  s1_ent_t         s1_q, s1_d;
  perm_word_t      m_dat_q, m_dat_d;
  logic            s1_adv, s2_adv;
  logic [PERM_LANES-1:0][PERM_AW-1:0] dst;

  always_comb begin
    s2_adv     = !vld_pipe_q[2] || m_ready;
    s1_adv     = !vld_pipe_q[1] || s2_adv;
    vld_pipe_d = vld_pipe_q;
    if (s2_adv) vld_pipe_d[2] = vld_pipe_q[1];
    if (s1_adv) vld_pipe_d[1] = s_valid;

    s1_d = s1_q;
    if (s1_adv && s_valid) begin
      s1_d.tag = s_dat[PERM_W-1 -: PERM_TW];
      for (int jj = 0; jj < PERM_LANES; jj++)
        for (int i = 0; i < PERM_LANES; i++)
          s1_d.hit[jj][i] = (s_dat[PERM_AW*i +: PERM_AW] == lane_addr_t'(jj));
    end

    m_dat_d = m_dat_q;
    if (s2_adv && vld_pipe_q[1]) m_dat_d = {s1_q.tag, dst};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      m_dat_q    <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      m_dat_q    <= m_dat_d;
    end
  end

  assign s_ready = s1_adv;
  assign m_valid = vld_pipe_q[2];
  assign m_dat   = m_dat_q;

`ifdef PERM_ADDR_INV_CHECK_EN
  logic        core_err;
  logic        m_err_q, m_err_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  perm_inv_core u_core (
    .hit (s1_q.hit),
    .dst (dst),
    .err (core_err)
  );

  always_comb begin
    m_err_d = m_err_q;
    if (s2_adv && vld_pipe_q[1]) m_err_d = core_err;
    err_cnt_d = err_cnt_q;
    if (m_valid && m_ready && m_err_q && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_err_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      m_err_q   <= m_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign m_err   = m_err_q;
  assign err_cnt = err_cnt_q;
`else
  perm_inv_core u_core (
    .hit (s1_q.hit),
    .dst (dst)
  );

  assign m_err   = 1'b0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_perm_addr_inv.sv
// Scoreboard bench for perm_addr_inv: random src words vs a lane-scan inverse model.
module tb_perm_addr_inv;
  import perm_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [67:0] s_dat = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [67:0] m_dat;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_err;
  logic [15:0] err_cnt;

  perm_addr_inv dut (
    .clk(clk), .reset(reset), .s_dat(s_dat), .s_valid(s_valid), .s_ready(s_ready),
    .m_dat(m_dat), .m_valid(m_valid), .m_ready(m_ready), .m_err(m_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [67:0] dat; logic err; } exp_t;
  exp_t exp_q[$];
  int   n_chk = 0, n_pass = 0;
  int   rdy_mode = 0, rdy_ph = 0;

`ifdef PERM_ADDR_INV_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  task automatic chk(input string name, input logic [67:0] got, input logic [67:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  // Each source lane claims its destination if nobody claimed it earlier.
  function automatic exp_t ref_inv(input logic [67:0] w);
    int         cnt[16];
    logic [3:0] d[16];
    int         s;
    exp_t       e;
    for (int j = 0; j < 16; j++) begin d[j] = 4'(j); cnt[j] = 0; end
    for (int i = 0; i < 16; i++) begin
      s = int'(w[4*i +: 4]);
      if (cnt[s] == 0) d[s] = 4'(i);
      cnt[s]++;
    end
    e.dat = '0;
    for (int j = 0; j < 16; j++) e.dat[4*j +: 4] = d[j];
    e.dat[67:64] = w[67:64];
    e.err = 1'b0;
    for (int j = 0; j < 16; j++) if (CHK && cnt[j] != 1) e.err = 1'b1;
    return e;
  endfunction

  function automatic logic [67:0] mk(input int kind, input logic [3:0] tag);
    logic [67:0] w;
    int a[16];
    int k, t;
    for (int i = 0; i < 16; i++) a[i] = i;
    case (kind)
      1: for (int i = 0; i < 16; i++) a[i] = 15 - i;
      2: for (int i = 0; i < 16; i++) a[i] = (i + 1) % 16;
      3: for (int i = 0; i < 16; i++) a[i] = 3;
      4: for (int i = 15; i > 0; i--) begin
           k = int'($urandom_range(0, i)); t = a[i]; a[i] = a[k]; a[k] = t;
         end
      5: for (int i = 0; i < 16; i++) a[i] = int'($urandom_range(0, 15));
      default: ;
    endcase
    w = '0;
    for (int i = 0; i < 16; i++) w[4*i +: 4] = 4'(a[i]);
    w[67:64] = tag;
    return w;
  endfunction

  function automatic logic next_rdy();
    logic r;
    case (rdy_mode)
      0: r = 1'b1;
      1: r = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
      2: r = 1'($urandom_range(0, 1));
      default: r = 1'b0;
    endcase
    rdy_ph++;
    return r;
  endfunction

  // Tasks start and end at posedge+2.
  task automatic send(input logic [67:0] w);
    logic acc;
    int   tmo;
    tmo = 0; acc = 1'b0;
    s_valid = 1'b1; s_dat = w;
    forever begin
      @(negedge clk); #1 acc = s_ready;
      @(posedge clk);
      if (acc) break;
      #2 m_ready = next_rdy();
      if (++tmo > 200) begin chk("send_timeout", 68'(0), 68'(1)); break; end
    end
    if (acc) exp_q.push_back(ref_inv(w));
    #2 s_valid = 1'b0; m_ready = next_rdy();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2 m_ready = next_rdy(); end
  endtask

  task automatic drain();
    int tmo;
    tmo = 0;
    rdy_mode = 0;
    while (exp_q.size() != 0 && tmo < 100) begin idle(1); tmo++; end
    idle(2);
    chk("drain_empty", 68'(exp_q.size()), 68'(0));
  endtask

  // Directed: empty pipe, m_ready=1, output must appear exactly two edges after accept.
  task automatic send_chk(input string name, input logic [67:0] w, input logic [67:0] want, input logic werr);
    rdy_mode = 0;
    send(w);
    @(negedge clk); chk({name, "_lat1"}, 68'(m_valid), 68'(0));
    @(posedge clk); #2;
    @(negedge clk);
    chk({name, "_vld"}, 68'(m_valid), 68'(1));
    chk({name, "_dat"}, m_dat, want);
    chk({name, "_err"}, 68'(m_err), 68'(werr));
    @(posedge clk); #2;
  endtask

  // Monitor/scoreboard
  int          occ = 0;
  logic [15:0] exp_cnt = '0;
  logic        hold = 1'b0, hold_err;
  logic [67:0] hold_dat;

  always @(negedge clk) begin
    if (reset) begin
      occ = 0; exp_cnt = '0; hold = 1'b0;
    end else begin
      chk("s_ready", 68'(s_ready), 68'(!(occ == 2 && !m_ready)));
      chk("err_cnt", 68'(err_cnt), 68'(exp_cnt));
      if (hold) begin
        chk("stall_dat", m_dat, hold_dat);
        chk("stall_err", 68'(m_err), 68'(hold_err));
      end
      if (m_valid) begin
        if (exp_q.size() == 0) chk("spurious_out", 68'(m_valid), 68'(0));
        else begin
          chk("m_dat", m_dat, exp_q[0].dat);
          chk("m_err", 68'(m_err), 68'(exp_q[0].err));
          if (m_ready) begin
            if (exp_q[0].err && exp_cnt != 16'hFFFF) exp_cnt++;
            void'(exp_q.pop_front());
          end
        end
      end
      hold = m_valid && !m_ready; hold_dat = m_dat; hold_err = m_err;
      occ = occ + int'(s_valid && s_ready) - int'(m_valid && m_ready);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_m_valid", 68'(m_valid), 68'(0));
    chk("rst_m_dat", m_dat, 68'(0));
    chk("rst_m_err", 68'(m_err), 68'(0));
    chk("rst_err_cnt", 68'(err_cnt), 68'(0));
    @(posedge clk); #2 reset = 1'b0; m_ready = 1'b1;
    @(negedge clk); chk("rst_s_ready", 68'(s_ready), 68'(1));
    @(posedge clk); #2;

    send_chk("ident", mk(0, 4'hA), {4'hA, 64'hFEDCBA9876543210}, 1'b0);
    send_chk("rev",   mk(1, 4'h5), {4'h5, 64'h0123456789ABCDEF}, 1'b0);
    send_chk("rot",   mk(2, 4'h0), {4'h0, 64'hEDCBA9876543210F}, 1'b0);
    send_chk("dup",   mk(3, 4'h3), {4'h3, 64'hFEDCBA9876540210}, CHK);
    @(negedge clk); chk("dup_cnt", 68'(err_cnt), 68'(CHK));
    @(posedge clk); #2;

    // Back-to-back with m_ready 1,0,0,1,...
    rdy_mode = 1; rdy_ph = 0;
    for (int n = 0; n < 8; n++) send(mk(4, 4'(n)));
    drain();

    rdy_mode = 2;
    for (int n = 0; n < 150; n++) begin
      send(mk(($urandom_range(0, 2) == 0) ? 5 : 4, 4'($urandom)));
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
    end
    drain();

    // Reset with two words in flight.
    rdy_mode = 3;
    send(mk(5, 4'h1));
    send(mk(3, 4'h2));
    idle(1);
    @(posedge clk); #3 reset = 1'b1;
    #1;
    chk("arst_m_valid", 68'(m_valid), 68'(0));
    chk("arst_err_cnt", 68'(err_cnt), 68'(0));
    chk("arst_m_err", 68'(m_err), 68'(0));
    exp_q.delete();
    @(posedge clk); #2 reset = 1'b0; rdy_mode = 0; m_ready = 1'b1;
    @(negedge clk); chk("arst_s_ready", 68'(s_ready), 68'(1));
    chk("arst_no_out", 68'(m_valid), 68'(0));
    @(posedge clk); #2;
    idle(4);

`ifdef PERM_ADDR_INV_CHECK_EN
    dut.err_cnt_q = 16'hFFFE;
    exp_cnt = 16'hFFFE;
    for (int n = 0; n < 3; n++) send(mk(3, 4'hE));
    drain();
    @(negedge clk); chk("sat_err_cnt", 68'(err_cnt), 68'(16'hFFFF));
    @(posedge clk); #2;
`endif

    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/perm_addr_inv.md
# perm_addr_inv

Inverse address encoder for the 16-lane permutation network. It takes a per-lane source-address word (lane i reads from lane src[i]) and produces the matching per-lane destination-address word (lane j is sent to lane dst[j]). It is the producer counterpart of the permutation address decoder. It sits between the scatter/gather control and the permutation datapath, in a 2-stage valid/ready pipeline, and flags any input that is not a bijection.

## Interface
- LANES, 16, number of permutation lanes
- AW, 4, address bits per lane (log2 LANES)
- TW, 4, tag bits carried above the address field
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- s_dat  input  LANES*AW+TW (68)  source-address word; lane i in [AW*i+AW-1:AW*i]; tag in [67:64]
- s_valid  input  1  s_dat valid
- s_ready  output  1  block accepts s_dat this cycle
- m_dat  output  68  destination-address word, same lane/tag packing as s_dat
- m_valid  output  1  m_dat valid
- m_ready  input  1  downstream accepts m_dat
- m_err  output  1  qualified by m_valid; input word was not a bijection
- err_cnt  output  16  count of words delivered with m_err=1; saturates at 0xFFFF

## Operation
- Transfer rules:
  - An input transfer occurs when s_valid&&s_ready.
  - An output transfer occurs when m_valid&&m_ready.
- Stage 1 (S1):
  - Registers s_dat.
  - Builds per-source one-hot destination vectors: hit[j][i] = (src[i]==j).
- Stage 2 (S2):
  - For each destination j, dst[j] = the lowest lane i with hit[j][i]=1.
  - If no lane hits j, dst[j] = j (identity fill).
  - Tag passes through unchanged.
  - m_err = 1 if any destination has zero hits or more than one hit.
- err_cnt increments by 1 on each output transfer with m_err=1. It holds at 0xFFFF.
- Stage advance: a stage loads when it is empty, or when its contents move on in the same cycle.
- s_ready = !S1_valid || (!S2_valid || m_ready). It is combinational from m_ready, with no bubble at full throughput.
- m_dat and m_err are held stable while m_valid=1 and m_ready=0.
- State per stage is VALID or EMPTY; nothing else.

## Timing
- Latency: a word accepted at cycle n appears on m_valid at n+2 if downstream does not stall.
- Throughput: 1 word/cycle while m_ready=1.
- Reset (asynchronous, active-high):
  - Both stages go EMPTY; m_valid=0, m_err=0, m_dat=0, err_cnt=0.
  - s_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation: in-flight words are dropped with no output transfer, and err_cnt clears.
- Full pipeline with m_ready=0: s_ready=0.
- Full pipeline, m_ready rising: a simultaneous accept and deliver shifts both stages in the same cycle.
- err_cnt at 0xFFFF with another error word: the value stays 0xFFFF.

## Configuration
- PERM_ADDR_INV_CHECK_EN defined:
  - Bijection check, m_err and err_cnt are implemented as above.
- Undefined:
  - m_err tied to 0, err_cnt tied to 0, check logic removed.
  - Inversion still uses the lowest-index-wins and identity-fill rules, so m_dat is identical either way.

## Structure
- Shared package perm_pkg holds:
  - PERM_LANES=16, PERM_AW=4, PERM_TW=4.
  - Word width PERM_W=68.
  - typedefs lane_addr_t (logic [3:0]) and perm_word_t (logic [67:0]).
- One sub-module, perm_inv_core: purely combinational. It maps the S1 one-hot matrix to dst[] and the error bit, and is instantiated once in S2.
- The handshake, stage registers and counter live in perm_addr_inv.

## Test plan
- Identity src[i]=i, tag=0xA, m_ready=1 -> after 2 cycles m_dat[63:0]=0xFEDCBA9876543210, m_dat[67:64]=0xA, m_err=0.
- Reverse src[i]=15-i -> dst[j]=15-j (m_dat[63:0]=0x0123456789ABCDEF), m_err=0. Rotate-by-1, src[i]=(i+1)%16 -> dst[j]=(j-1)%16.
- Duplicate src = all lanes 0x3 -> dst[3]=0, every other dst[j]=j, m_err=1, err_cnt=1.
- Back-to-back 8 words with m_ready toggling 1,0,0,1,... -> no loss or duplication, order preserved, m_dat stable during stalls, s_ready=0 whenever both stages full and m_ready=0.
- Reset asserted with 2 words in flight and err_cnt=5 -> m_valid=0 and err_cnt=0 immediately (asynchronous), no output transfer of the dropped words.
- Force err_cnt to 0xFFFE, send 3 error words -> err_cnt reads 0xFFFF, 0xFFFF, 0xFFFF. With PERM_ADDR_INV_CHECK_EN undefined -> m_err=0, err_cnt=0, and m_dat matches the checked build.
